pc_stack_unit: RTL and testbench
================================

Name: pc_stack_unit

Overview:
- Next-generation program counter for the RAT MCU.
- Parametrised in address width; adds a selectable interrupt vector and a reset vector.
- Integrates a hardware return-address stack (LIFO) of configurable depth, so CALL/RET need no scratch RAM.
- Sits between the control unit (load, increment, select, push, pop) and the instruction memory address input.

Parameters:
- ADDR_W, 10: width of PC, immediate and stack entries.
- DEPTH, 8: return-stack entries (>=2).
- INTR_VEC, 10'h3FF: address loaded on PC_SEL=2; sized to ADDR_W.
- RESET_VEC, 10'h000: PC value after reset and on PC_SEL=3; sized to ADDR_W.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset
- PC_LD  in  1  load PC from the selected source
- PC_INC  in  1  increment PC (ignored when PC_LD=1)
- PC_SEL  in  2  source select: 0 FROM_IMMED, 1 stack top, 2 INTR_VEC, 3 RESET_VEC
- FROM_IMMED  in  ADDR_W  branch/call target
- PUSH  in  1  push return address (PC_COUNT+1, modulo 2^ADDR_W)
- POP  in  1  pop the stack top
- PC_COUNT  out  ADDR_W  current PC, registered
- STACK_TOP  out  ADDR_W  top entry, combinational from registers; 0 when empty
- SP_LEVEL  out  $clog2(DEPTH+1)  number of valid entries
- FULL  out  1  SP_LEVEL==DEPTH
- EMPTY  out  1  SP_LEVEL==0
- ERR  out  1  sticky stack-misuse flag

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - PC_COUNT=RESET_VEC, SP_LEVEL=0, ERR=0, stack contents don't-care.
  - Reset overrides every other input that cycle.
- PC update priority per edge: reset > PC_LD > PC_INC > hold.
  - PC_LD=1: PC_COUNT <= selected source.
  - PC_INC=1 (PC_LD=0): PC_COUNT <= PC_COUNT+1, wrapping from all-ones to 0.
  - Neither asserted: hold.
- Latency: all PC updates take one cycle; PC_COUNT is visible the cycle after the edge.
- PC_SEL=1 with a non-empty stack loads the STACK_TOP value present before the edge. A RET is therefore PC_LD=1, PC_SEL=1, POP=1 in one cycle.
- PC_SEL=1 with an empty stack loads RESET_VEC and sets ERR.
- Stack operations per edge:
  - PUSH only, not full: entry[SP_LEVEL] <= PC_COUNT+1 (pre-edge PC), SP_LEVEL++.
  - PUSH only, full: push ignored, contents unchanged, ERR <= 1.
  - POP only, not empty: SP_LEVEL--.
  - POP only, empty: ignored, ERR <= 1.
  - PUSH and POP together, non-empty: replace the top with PC_COUNT+1; SP_LEVEL unchanged; no error even if full.
  - PUSH and POP together, empty: treated as a plain push; no ERR.
- A CALL is PUSH=1, PC_LD=1, PC_SEL=0 in one cycle. The pushed value uses the pre-edge PC.
- Stack ops are independent of PC_LD/PC_INC. Both update on the same edge.
- ERR is cleared only by reset.
- FULL, EMPTY and SP_LEVEL are derived from the registered level; there is no extra latency.
- Reset mid-sequence (e.g. during a nested call chain) discards all stack entries.
- Widths:
  - +1 arithmetic is ADDR_W bits; the carry is discarded.
  - SP_LEVEL is $clog2(DEPTH+1) bits.
  - Non-power-of-2 DEPTH must work.

Decomposition:
- Shared package pc_pkg:
  - enum pc_sel_t {PC_SRC_IMMED=0, PC_SRC_STACK=1, PC_SRC_INTR=2, PC_SRC_RESET=3}.
  - Default vector constants.
- Sub-module ret_stack (parametrised LIFO):
  - Parameters: ADDR_W, DEPTH.
  - Inputs: PUSH, POP, DIN.
  - Outputs: TOP, LEVEL, FULL, EMPTY, ERR.
- pc_stack_unit holds the PC register and source mux, and instantiates ret_stack.

Test Plan (ADDR_W=10, DEPTH=4, INTR_VEC=10'h3FF, RESET_VEC=0):
1. RST_N=0 for one edge, then PC_INC=1 for 3 edges -> PC_COUNT 0,1,2,3; EMPTY=1, ERR=0. Then PC_INC=0 for 2 edges -> PC holds 3.
2. Load and select: PC_LD=1, PC_SEL=0, FROM_IMMED=10'h3FE -> PC=10'h3FE. Then PC_LD=0, PC_INC=1 -> 10'h3FF, then 10'h000 (wrap). Then PC_LD=1, PC_SEL=2 -> 10'h3FF. Then PC_SEL=3 -> 0.
3. CALL/RET: at PC=5, PUSH=1, PC_LD=1, PC_SEL=0, FROM_IMMED=40 -> PC=40, STACK_TOP=6, SP_LEVEL=1. At PC=41, POP=1, PC_LD=1, PC_SEL=1 -> PC=6, EMPTY=1, ERR=0.
4. Overflow: push 4 times from PC=10,20,30,40 -> FULL=1, STACK_TOP=41. A 5th PUSH -> SP_LEVEL stays 4, STACK_TOP stays 41, ERR=1.
5. Underflow and empty return: reset, then POP=1 -> ERR=1, SP_LEVEL=0. Reset again, then PC_LD=1, PC_SEL=1 with the stack empty -> PC=0, ERR=1.
6. Simultaneous and reset-dominance:
   - With 2 entries, top=15: PUSH+POP at PC=99 -> SP_LEVEL=2, STACK_TOP=100.
   - Then RST_N=0 together with PC_LD=1, PUSH=1 -> PC=0, SP_LEVEL=0, ERR=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program counter and return stack.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SRC_IMMED = 2'd0,
    PC_SRC_STACK = 2'd1,
    PC_SRC_INTR  = 2'd2,
    PC_SRC_RESET = 2'd3
  } pc_sel_t;

  localparam int              DEF_ADDR_W    = 10;
  localparam int              DEF_DEPTH     = 8;
  localparam logic [9:0]      DEF_INTR_VEC  = 10'h3FF;
  localparam logic [9:0]      DEF_RESET_VEC = 10'h000;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; writes and level updates take effect on the next edge.
// TOP reads the current top entry combinationally and is 0 when the stack is empty.
module ret_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [ADDR_W-1:0]          i_din,
  output logic [ADDR_W-1:0]          o_top,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_err
);

  localparam int LVL_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0]  r_level;
  logic              r_err;

  logic              w_empty;
  logic              w_full;
  logic              w_wr_en;
  logic [LVL_W-1:0]  w_wr_idx;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              w_err_set;
  logic [ADDR_W-1:0] w_top;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LVL_W'(DEPTH));

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = r_level;
    w_level_nxt = r_level;
    w_err_set   = 1'b0;
    if (i_push && i_pop) begin
      // Replace-top never overflows; on an empty stack it degrades to a push.
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_wr_idx    = '0;
        w_level_nxt = LVL_W'(1);
      end else begin
        w_wr_idx = r_level - LVL_W'(1);
      end
    end else if (i_push) begin
      if (w_full) begin
        w_err_set = 1'b1;
      end else begin
        w_wr_en     = 1'b1;
        w_level_nxt = r_level + LVL_W'(1);
      end
    end else if (i_pop) begin
      if (w_empty) begin
        w_err_set = 1'b1;
      end else begin
        w_level_nxt = r_level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level <= '0;
      r_err   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // Entry storage needs no reset: entries above the level are never observed.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_en && (w_wr_idx == LVL_W'(i))) begin
        r_mem[i] <= i_din;
      end
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_level == LVL_W'(i + 1)) begin
        w_top = r_mem[i];
      end
    end
  end

  assign o_top   = w_top;
  assign o_level = r_level;
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_err   = r_err;

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with selectable load source and an integrated return-address stack.
// PC and stack update together on each edge; PC_COUNT is visible one cycle later.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] INTR_VEC  = DEF_INTR_VEC,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEF_RESET_VEC
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_pc_ld,
  input  logic                       i_pc_inc,
  input  logic [1:0]                 i_pc_sel,
  input  logic [ADDR_W-1:0]          i_from_immed,
  input  logic                       i_push,
  input  logic                       i_pop,
  output logic [ADDR_W-1:0]          o_pc_count,
  output logic [ADDR_W-1:0]          o_stack_top,
  output logic [$clog2(DEPTH+1)-1:0] o_sp_level,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_err
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_sel_err;

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_src;
  logic              w_sel_err;
  logic [ADDR_W-1:0] w_top;
  logic              w_empty;
  logic              w_stk_err;

  // Carry is dropped so the PC wraps from all-ones to zero.
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_comb begin
    w_src     = RESET_VEC;
    w_sel_err = 1'b0;
    case (pc_sel_t'(i_pc_sel))
      PC_SRC_IMMED: w_src = i_from_immed;
      PC_SRC_STACK: begin
        // Returning with nothing on the stack restarts at the reset vector.
        if (w_empty) begin
          w_src     = RESET_VEC;
          w_sel_err = 1'b1;
        end else begin
          w_src = w_top;
        end
      end
      PC_SRC_INTR:  w_src = INTR_VEC;
      PC_SRC_RESET: w_src = RESET_VEC;
      default:      w_src = RESET_VEC;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc      <= RESET_VEC;
      r_sel_err <= 1'b0;
    end else begin
      if (i_pc_ld) begin
        r_pc <= w_src;
      end else if (i_pc_inc) begin
        r_pc <= w_pc_inc;
      end
      if (i_pc_ld && w_sel_err) begin
        r_sel_err <= 1'b1;
      end
    end
  end

  ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_push),
    .i_pop   (i_pop),
    .i_din   (w_pc_inc),
    .o_top   (w_top),
    .o_level (o_sp_level),
    .o_full  (o_full),
    .o_empty (w_empty),
    .o_err   (w_stk_err)
  );

  assign o_pc_count  = r_pc;
  assign o_stack_top = w_top;
  assign o_empty     = w_empty;
  assign o_err       = w_stk_err | r_sel_err;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed scoreboard bench for pc_stack_unit with a 4-entry return stack.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pc_ld = 1'b0;
  logic       pc_inc = 1'b0;
  logic [1:0] pc_sel = 2'd0;
  logic [9:0] from_immed = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [9:0] pc_count;
  logic [9:0] stack_top;
  logic [2:0] sp_level;
  logic       full;
  logic       empty;
  logic       err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [9:0] pc;
    logic [9:0] top;
    logic [2:0] lvl;
    logic       err;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  pc_stack_unit #(
    .ADDR_W    (10),
    .DEPTH     (4),
    .INTR_VEC  (10'h3FF),
    .RESET_VEC (10'h000)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_pc_ld      (pc_ld),
    .i_pc_inc     (pc_inc),
    .i_pc_sel     (pc_sel),
    .i_from_immed (from_immed),
    .i_push       (push),
    .i_pop        (pop),
    .o_pc_count   (pc_count),
    .o_stack_top  (stack_top),
    .o_sp_level   (sp_level),
    .o_full       (full),
    .o_empty      (empty),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then queue the state expected after that edge.
  task automatic step(input logic r, input logic ld, input logic inc, input logic [1:0] sel,
                      input logic [9:0] imm, input logic ps, input logic pp, input string nm,
                      input logic [9:0] e_pc, input logic [9:0] e_top, input logic [2:0] e_lvl,
                      input logic e_err);
    exp_t e;
    @(negedge clk);
    rst_n = r; pc_ld = ld; pc_inc = inc; pc_sel = sel; from_immed = imm; push = ps; pop = pp;
    @(posedge clk);
    e.pc = e_pc; e.top = e_top; e.lvl = e_lvl; e.err = e_err; e.nm = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle the DUT has a queued expectation, compare its registered outputs.
  initial begin
    exp_t e;
    logic e_full, e_empty;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        e_full  = (e.lvl == 3'd4);
        e_empty = (e.lvl == 3'd0);
        total++;
        if (pc_count !== e.pc || stack_top !== e.top || sp_level !== e.lvl ||
            full !== e_full || empty !== e_empty || err !== e.err) begin
          bad++;
          $display("FAIL %s: got pc=%h top=%h lvl=%0d full=%b empty=%b err=%b, want pc=%h top=%h lvl=%0d full=%b empty=%b err=%b",
                   e.nm, pc_count, stack_top, sp_level, full, empty, err,
                   e.pc, e.top, e.lvl, e_full, e_empty, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //   rst   ld    inc   sel   imm      psh   pop   name               pc       top      lvl   err
    // 1. reset, increment, hold
    step(1'b0, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "reset",           10'd0,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc1",            10'd1,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc2",            10'd2,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc3",            10'd3,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "hold1",           10'd3,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "hold2",           10'd3,   10'd0,   3'd0, 1'b0);
    // 2. load beats increment, wrap, interrupt and reset vectors
    step(1'b1, 1'b1, 1'b1, 2'd0, 10'h3FE, 1'b0, 1'b0, "ld_immed",        10'h3FE, 10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc_3ff",         10'h3FF, 10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc_wrap",        10'h000, 10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd2, 10'd0,   1'b0, 1'b0, "ld_intr",         10'h3FF, 10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd3, 10'd0,   1'b0, 1'b0, "ld_rstvec",       10'h000, 10'd0,   3'd0, 1'b0);
    // 3. CALL / RET
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd5,   1'b0, 1'b0, "ld_5",            10'd5,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd40,  1'b1, 1'b0, "call",            10'd40,  10'd6,   3'd1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b0, 1'b0, "inc_41",          10'd41,  10'd6,   3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'd0,   1'b0, 1'b1, "ret",             10'd6,   10'd0,   3'd0, 1'b0);
    // 4. overflow
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd10,  1'b0, 1'b0, "ld_10",           10'd10,  10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd20,  1'b1, 1'b0, "push1",           10'd20,  10'd11,  3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd30,  1'b1, 1'b0, "push2",           10'd30,  10'd21,  3'd2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd40,  1'b1, 1'b0, "push3",           10'd40,  10'd31,  3'd3, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b1, 1'b0, "push4_full",      10'd40,  10'd41,  3'd4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b1, 1'b0, "push5_ovf",       10'd40,  10'd41,  3'd4, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b1, "pop_after_ovf",   10'd40,  10'd31,  3'd3, 1'b1);
    // 5. underflow and empty return
    step(1'b0, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "reset2",          10'd0,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b1, "pop_empty",       10'd0,   10'd0,   3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "reset3",          10'd0,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd7,   1'b0, 1'b0, "ld_7",            10'd7,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd1, 10'd0,   1'b0, 1'b0, "ret_empty",       10'd0,   10'd0,   3'd0, 1'b1);
    // 6. push+pop on empty, replace-top, reset dominance
    step(1'b0, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b0, "reset4",          10'd0,   10'd0,   3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b1, 1'b1, "pushpop_empty",   10'd0,   10'd1,   3'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd14,  1'b0, 1'b0, "ld_14",           10'd14,  10'd1,   3'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b1, 1'b0, "push_15",         10'd14,  10'd15,  3'd2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 10'd99,  1'b0, 1'b0, "ld_99",           10'd99,  10'd15,  3'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b1, 1'b1, "pushpop_replace", 10'd99,  10'd100, 3'd2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 10'd0,   1'b0, 1'b1, "pop_below",       10'd99,  10'd1,   3'd1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'd0, 10'd0,   1'b1, 1'b0, "push_inc",        10'd100, 10'd100, 3'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 10'd55,  1'b1, 1'b0, "reset_dominates", 10'd0,   10'd0,   3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; pc_ld = 1'b0; pc_inc = 1'b0; push = 1'b0; pop = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
